// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one operation at a time to a combinational ALU.
// It holds the operands stable for the op's latency, captures the result and
// Zero flag into a first-word-fall-through FIFO, and keeps issue/zero counters.
module alu_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [31:0]      cmd_a_i,
    input  logic [31:0]      cmd_b_i,
    output logic [31:0]      alu_data1_o,
    output logic [31:0]      alu_data2_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [31:0]      alu_data_i,
    input  logic             alu_zero_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_data_o,
    output logic             res_zero_o,
    output logic [2:0]       res_op_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] issued_cnt_o,
    output logic [CNT_W-1:0] zero_cnt_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int HOLD_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [2:0]        OP_MUL   = 3'b110;
    localparam logic [HOLD_W-1:0] HOLD_MUL = HOLD_W'(MUL_CYCLES - 1);
    localparam logic [PTR_W:0]    DEPTH    = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic              accept;
    logic              capture;
    logic              pop;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_count;
    logic [31:0]       mem_data [FIFO_DEPTH];
    logic              mem_zero [FIFO_DEPTH];
    logic [2:0]        mem_op   [FIFO_DEPTH];

    // Next-state and handshake decode; ready depends only on state and fill level.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next  = state;
        cmd_ready_o = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = (fifo_count < DEPTH);
                accept      = cmd_valid_i && cmd_ready_o;
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (hold_cnt == '0) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ALU operand registers, hold counter and status counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_data1_o  <= '0;
            alu_data2_o  <= '0;
            alu_ctrl_o   <= '0;
            hold_cnt     <= '0;
            issued_cnt_o <= '0;
            zero_cnt_o   <= '0;
        end else begin
            if (accept) begin
                alu_data1_o  <= cmd_a_i;
                alu_data2_o  <= cmd_b_i;
                alu_ctrl_o   <= cmd_op_i;
                hold_cnt     <= (cmd_op_i == OP_MUL) ? HOLD_MUL : '0;
                issued_cnt_o <= issued_cnt_o + CNT_W'(1);
            end else if (state == EXEC && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            if (capture && alu_zero_i) begin
                zero_cnt_o <= zero_cnt_o + CNT_W'(1);
            end
        end
    end

    assign busy_o      = (state == EXEC);
    assign res_valid_o = (fifo_count != '0);
    assign pop         = res_valid_o && res_ready_i;
    assign res_data_o  = mem_data[rd_ptr];
    assign res_zero_o  = mem_zero[rd_ptr];
    assign res_op_o    = mem_op[rd_ptr];

    // Result FIFO: storage, pointers and fill level; push and pop may share an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            // NOTE: storage is cleared on reset because the head outputs read it directly and must be 0.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_zero[i] <= 1'b0;
                mem_op[i]   <= '0;
            end
        end else begin
            if (capture) begin
                mem_data[wr_ptr] <= alu_data_i;
                mem_zero[wr_ptr] <= alu_zero_i;
                mem_op[wr_ptr]   <= alu_ctrl_o;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a behavioural
// combinational ALU attached. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_alu_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i;
    logic [31:0] cmd_a_i;
    logic [31:0] cmd_b_i;
    logic [31:0] alu_data1_o;
    logic [31:0] alu_data2_o;
    logic [2:0]  alu_ctrl_o;
    logic [31:0] alu_data_i;
    logic        alu_zero_i;
    logic        res_valid_o;
    logic        res_ready_i;
    logic [31:0] res_data_o;
    logic        res_zero_o;
    logic [2:0]  res_op_o;
    logic        busy_o;
    logic [15:0] issued_cnt_o;
    logic [15:0] zero_cnt_o;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl #(.FIFO_DEPTH(4), .MUL_CYCLES(2), .CNT_W(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_a_i      (cmd_a_i),
        .cmd_b_i      (cmd_b_i),
        .alu_data1_o  (alu_data1_o),
        .alu_data2_o  (alu_data2_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_data_i   (alu_data_i),
        .alu_zero_i   (alu_zero_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_zero_o   (res_zero_o),
        .res_op_o     (res_op_o),
        .busy_o       (busy_o),
        .issued_cnt_o (issued_cnt_o),
        .zero_cnt_o   (zero_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural ALU: unknown codes pass data1, Zero means operands equal.
    always_comb begin
        alu_data_i = alu_data1_o;
        case (alu_ctrl_o)
            3'b001:  alu_data_i = alu_data1_o + alu_data2_o;
            3'b010:  alu_data_i = alu_data1_o - alu_data2_o;
            3'b011:  alu_data_i = alu_data1_o & alu_data2_o;
            3'b100:  alu_data_i = alu_data1_o | alu_data2_o;
            3'b101:  alu_data_i = alu_data1_o ^ alu_data2_o;
            3'b110:  alu_data_i = alu_data1_o * alu_data2_o;
            default: alu_data_i = alu_data1_o;
        endcase
        alu_zero_i = (alu_data1_o == alu_data2_o);
    end

    // Absolute time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid_o); end
        checks++; if (res_data_o !== 32'd0) begin errors++; $display("FAIL rst_res_data got %h exp 0", res_data_o); end
        checks++; if (res_op_o !== 3'd0 || res_zero_o !== 1'b0) begin errors++; $display("FAIL rst_res_op_zero got %b/%b exp 000/0", res_op_o, res_zero_o); end
        checks++; if (alu_data1_o !== 32'd0 || alu_data2_o !== 32'd0 || alu_ctrl_o !== 3'd0) begin errors++; $display("FAIL rst_alu got %h %h %b exp 0", alu_data1_o, alu_data2_o, alu_ctrl_o); end
        checks++; if (issued_cnt_o !== 16'd0 || zero_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_counters got %0d %0d exp 0 0", issued_cnt_o, zero_cnt_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready_o); end
    endtask

    task automatic test_sub();
        cmd_valid_i = 1'b1; cmd_op_i = 3'b010; cmd_a_i = 32'd7; cmd_b_i = 32'd7; res_ready_i = 1'b1;
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL sub_ready got %b exp 1", cmd_ready_o); end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        checks++; if (alu_ctrl_o !== 3'b010 || alu_data1_o !== 32'd7 || alu_data2_o !== 32'd7) begin errors++; $display("FAIL sub_alu got %b %h %h exp 010 7 7", alu_ctrl_o, alu_data1_o, alu_data2_o); end
        checks++; if (busy_o !== 1'b1 || res_valid_o !== 1'b0) begin errors++; $display("FAIL sub_exec got busy %b valid %b exp 1 0", busy_o, res_valid_o); end
        checks++; if (issued_cnt_o !== 16'd1) begin errors++; $display("FAIL sub_issued got %0d exp 1", issued_cnt_o); end
        @(negedge clk_i);
        checks++; if (res_valid_o !== 1'b1) begin errors++; $display("FAIL sub_res_valid got %b exp 1", res_valid_o); end
        checks++; if (res_data_o !== 32'd0 || res_zero_o !== 1'b1 || res_op_o !== 3'b010) begin errors++; $display("FAIL sub_res got %h %b %b exp 0 1 010", res_data_o, res_zero_o, res_op_o); end
        checks++; if (zero_cnt_o !== 16'd1 || busy_o !== 1'b0) begin errors++; $display("FAIL sub_zero_cnt got %0d busy %b exp 1 0", zero_cnt_o, busy_o); end
        @(negedge clk_i);
        res_ready_i = 1'b0;
        checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL sub_popped got %b exp 0", res_valid_o); end
    endtask

    task automatic test_mul();
        cmd_valid_i = 1'b1; cmd_op_i = 3'b110; cmd_a_i = 32'd3; cmd_b_i = 32'd5;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b1 || res_valid_o !== 1'b0) begin errors++; $display("FAIL mul_c1 got busy %b valid %b exp 1 0", busy_o, res_valid_o); end
        checks++; if (alu_ctrl_o !== 3'b110 || alu_data1_o !== 32'd3 || alu_data2_o !== 32'd5) begin errors++; $display("FAIL mul_alu_c1 got %b %h %h exp 110 3 5", alu_ctrl_o, alu_data1_o, alu_data2_o); end
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL mul_ready_exec got %b exp 0", cmd_ready_o); end
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b1 || res_valid_o !== 1'b0) begin errors++; $display("FAIL mul_c2 got busy %b valid %b exp 1 0", busy_o, res_valid_o); end
        checks++; if (alu_ctrl_o !== 3'b110 || alu_data1_o !== 32'd3 || alu_data2_o !== 32'd5) begin errors++; $display("FAIL mul_alu_c2 got %b %h %h exp 110 3 5", alu_ctrl_o, alu_data1_o, alu_data2_o); end
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0 || res_valid_o !== 1'b1) begin errors++; $display("FAIL mul_done got busy %b valid %b exp 0 1", busy_o, res_valid_o); end
        checks++; if (res_data_o !== 32'd15 || res_zero_o !== 1'b0 || res_op_o !== 3'b110) begin errors++; $display("FAIL mul_res got %0d %b %b exp 15 0 110", res_data_o, res_zero_o, res_op_o); end
        checks++; if (issued_cnt_o !== 16'd2 || zero_cnt_o !== 16'd1) begin errors++; $display("FAIL mul_counters got %0d %0d exp 2 1", issued_cnt_o, zero_cnt_o); end
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL mul_popped got %b exp 0", res_valid_o); end
    endtask

    task automatic test_full();
        res_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cmd_valid_i = 1'b1; cmd_op_i = 3'b001; cmd_a_i = 32'(i); cmd_b_i = 32'(i);
            checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL full_fill_ready%0d got %b exp 1", i, cmd_ready_o); end
            @(negedge clk_i);
            cmd_valid_i = 1'b0;
            @(negedge clk_i);
        end
        cmd_valid_i = 1'b1; cmd_a_i = 32'd5; cmd_b_i = 32'd5;
        checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", cmd_ready_o); end
        checks++; if (res_data_o !== 32'd2 || res_zero_o !== 1'b1) begin errors++; $display("FAIL full_head got %0d %b exp 2 1", res_data_o, res_zero_o); end
        @(negedge clk_i);
        checks++; if (cmd_ready_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL full_stall got ready %b busy %b exp 0 0", cmd_ready_o, busy_o); end
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", cmd_ready_o); end
        checks++; if (res_data_o !== 32'd4) begin errors++; $display("FAIL full_head_after_pop got %0d exp 4", res_data_o); end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        checks++; if (busy_o !== 1'b1 || issued_cnt_o !== 16'd7) begin errors++; $display("FAIL full_fifth_accept got busy %b issued %0d exp 1 7", busy_o, issued_cnt_o); end
        @(negedge clk_i);
        res_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (res_valid_o !== 1'b1 || res_data_o !== 32'(2 * (k + 2))) begin errors++; $display("FAIL full_drain%0d got %b %0d exp 1 %0d", k, res_valid_o, res_data_o, 2 * (k + 2)); end
            @(negedge clk_i);
        end
        res_ready_i = 1'b0;
        checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL full_empty got %b exp 0", res_valid_o); end
        checks++; if (zero_cnt_o !== 16'd6) begin errors++; $display("FAIL full_zero_cnt got %0d exp 6", zero_cnt_o); end
    endtask

    task automatic test_simul_push_pop();
        res_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cmd_valid_i = 1'b1; cmd_op_i = 3'b001; cmd_a_i = 32'(10 * i); cmd_b_i = 32'(i);
            @(negedge clk_i);
            cmd_valid_i = 1'b0;
            @(negedge clk_i);
        end
        cmd_valid_i = 1'b1; cmd_a_i = 32'd40; cmd_b_i = 32'd4;
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL simul_ready3 got %b exp 1", cmd_ready_o); end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        res_ready_i = 1'b1;
        checks++; if (res_data_o !== 32'd11) begin errors++; $display("FAIL simul_head_before got %0d exp 11", res_data_o); end
        @(negedge clk_i);
        res_ready_i = 1'b0;
        checks++; if (res_data_o !== 32'd22 || res_valid_o !== 1'b1) begin errors++; $display("FAIL simul_head_after got %0d %b exp 22 1", res_data_o, res_valid_o); end
        checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL simul_ready_count3 got %b exp 1", cmd_ready_o); end
        res_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (res_valid_o !== 1'b1 || res_data_o !== 32'(11 * (k + 2))) begin errors++; $display("FAIL simul_drain%0d got %b %0d exp 1 %0d", k, res_valid_o, res_data_o, 11 * (k + 2)); end
            @(negedge clk_i);
        end
        res_ready_i = 1'b0;
        checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL simul_empty got %b exp 0", res_valid_o); end
        checks++; if (issued_cnt_o !== 16'd11 || zero_cnt_o !== 16'd6) begin errors++; $display("FAIL simul_counters got %0d %0d exp 11 6", issued_cnt_o, zero_cnt_o); end
    endtask

    task automatic test_reset_mid_mul();
        res_ready_i = 1'b0;
        cmd_valid_i = 1'b1; cmd_op_i = 3'b110; cmd_a_i = 32'd3; cmd_b_i = 32'd5;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checks++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL rmul_ready got %b busy %b exp 1 0", cmd_ready_o, busy_o); end
        checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL rmul_valid got %b exp 0", res_valid_o); end
        checks++; if (issued_cnt_o !== 16'd0 || zero_cnt_o !== 16'd0) begin errors++; $display("FAIL rmul_counters got %0d %0d exp 0 0", issued_cnt_o, zero_cnt_o); end
        checks++; if (alu_ctrl_o !== 3'd0 || alu_data1_o !== 32'd0) begin errors++; $display("FAIL rmul_alu got %b %h exp 0 0", alu_ctrl_o, alu_data1_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        checks++; if (res_valid_o !== 1'b0 || zero_cnt_o !== 16'd0) begin errors++; $display("FAIL rmul_late got %b %0d exp 0 0", res_valid_o, zero_cnt_o); end
    endtask

    task automatic test_unknown_op();
        res_ready_i = 1'b0;
        cmd_valid_i = 1'b1; cmd_op_i = 3'b111; cmd_a_i = 32'hDEADBEEF; cmd_b_i = 32'd0;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        checks++; if (issued_cnt_o !== 16'd1 || busy_o !== 1'b1) begin errors++; $display("FAIL unk_issue got %0d busy %b exp 1 1", issued_cnt_o, busy_o); end
        @(negedge clk_i);
        checks++; if (res_valid_o !== 1'b1 || res_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL unk_data got %b %h exp 1 deadbeef", res_valid_o, res_data_o); end
        checks++; if (res_op_o !== 3'b111 || res_zero_o !== 1'b0) begin errors++; $display("FAIL unk_op got %b %b exp 111 0", res_op_o, res_zero_o); end
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
        checks++; if (res_valid_o !== 1'b0) begin errors++; $display("FAIL unk_popped got %b exp 0", res_valid_o); end
    endtask

    initial begin
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 3'b000;
        cmd_a_i     = 32'd0;
        cmd_b_i     = 32'd0;
        res_ready_i = 1'b0;
        test_reset();
        test_sub();
        test_mul();
        test_full();
        test_simul_push_pop();
        test_reset_mid_mul();
        test_unknown_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencer that drives the ALU operand/control inputs (data1, data2, 3-bit ALUCtrl) and consumes its result and Zero flag.
- Accepts operation commands over a valid/ready stream and holds the ALU inputs stable for the required number of cycles, longer for MUL.
- Captures result and Zero flag into a small result FIFO, which is drained over a second valid/ready stream.
- Sits between the CGRA PE command path and the combinational ALU.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.
- MUL_CYCLES, 2, cycles ALU inputs are held for MUL (op 3'b110); at least 1.
- CNT_W, 16, width of the status counters.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted this cycle when high together with cmd_valid_i.
- cmd_op_i  in  3  ALU control code: 001 SUM, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 MUL; others pass data1.
- cmd_a_i  in  32  operand 1.
- cmd_b_i  in  32  operand 2.
- alu_data1_o  out  32  registered ALU operand 1.
- alu_data2_o  out  32  registered ALU operand 2.
- alu_ctrl_o  out  3  registered ALU control.
- alu_data_i  in  32  ALU result.
- alu_zero_i  in  1  ALU Zero flag (operands equal).
- res_valid_o  out  1  FIFO head valid.
- res_ready_i  in  1  consumer pops the head when high together with res_valid_o.
- res_data_o  out  32  head result.
- res_zero_o  out  1  head Zero flag.
- res_op_o  out  3  head opcode.
- busy_o  out  1  high while the FSM is in EXEC.
- issued_cnt_o  out  CNT_W  commands accepted, wrapping.
- zero_cnt_o  out  CNT_W  results captured with Zero=1, wrapping.

Behaviour:
- Reset (rst_i high at an edge):
  - alu_data1_o, alu_data2_o, alu_ctrl_o = 0.
  - FIFO emptied: res_valid_o = 0; res_data_o, res_zero_o, res_op_o = 0.
  - Counters = 0; FSM = IDLE; busy_o = 0.
  - Any in-flight operation is discarded, with no capture and no count.
- FSM states: IDLE, EXEC.
- IDLE:
  - cmd_ready_o = (fifo_count < FIFO_DEPTH); combinational from state and count only, never from cmd_valid_i.
  - On accept at edge N: alu_* registers load the command, issued_cnt_o increments, and the FSM moves to EXEC.
  - Hold counter loads MUL_CYCLES-1 for op 110, else 0.
- EXEC:
  - cmd_ready_o = 0; alu_* outputs remain stable.
  - Hold counter != 0: decrement.
  - Hold counter == 0: push {alu_data_i, alu_zero_i, alu_ctrl_o} into the FIFO, increment zero_cnt_o if alu_zero_i, return to IDLE.
  - alu_* outputs keep their last values after capture; they are not cleared.
- Latency:
  - Non-MUL: accept at edge N, capture at edge N+1; res_valid_o high after N+1 if the FIFO was empty.
  - MUL: capture at edge N+MUL_CYCLES.
  - Peak throughput is one non-MUL op per 2 cycles.
- FIFO:
  - First-word-fall-through; head outputs are registered/stored values.
  - A pop and a push at the same edge leave the count unchanged and are both legal, including at count = FIFO_DEPTH-1 or FIFO_DEPTH.
  - A push never occurs when full, because space is checked at accept time and only one op is ever in flight.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Empty: res_valid_o = 0; res_* outputs hold the last head value and have no meaning.
- Full: cmd_ready_o = 0 in IDLE until a pop; a pop at edge M makes cmd_ready_o high after M.
- Unknown opcode (000, 111): issued as a normal 1-cycle op. The result is whatever the ALU returns, its pass-through of data1, and res_op_o carries the raw code.
- Counters wrap from all-ones to 0 without saturation.
- rst_i takes priority over every simultaneous event.

Test Plan:
- SUB, no backpressure: cmd op=010, a=7, b=7, res_ready_i=1 -> alu_ctrl_o=010 one cycle after accept; res_valid_o after the next edge with res_data_o=0, res_zero_o=1, res_op_o=010; zero_cnt_o=1, issued_cnt_o=1.
- MUL hold: op=110, a=3, b=5, MUL_CYCLES=2 -> alu_* stable for 2 cycles; capture at N+2 with res_data_o=15, res_zero_o=0; busy_o high for exactly 2 cycles.
- Full FIFO backpressure: res_ready_i=0, five SUM commands (1+1, 2+2, 3+3, 4+4, 5+5) -> four accepted, cmd_ready_o=0 with the fifth pending. Pulse res_ready_i for one cycle -> 2 popped, fifth accepted; pop order is 2, 4, 6, 8, 10.
- Simultaneous push/pop at count FIFO_DEPTH-1: pop and capture land on the same edge -> count unchanged, order preserved, no lost or duplicated entry.
- Reset mid-MUL: assert rst_i one cycle after accepting op=110 -> no result appears; res_valid_o=0, counters=0, cmd_ready_o=1 the cycle after reset deasserts.
- Unknown op 111, a=0xDEADBEEF, b=0 -> res_data_o=0xDEADBEEF, res_op_o=111; issued_cnt_o increments.
